// File: rtl/div_pkg.sv
// Shared widths, ALU codes, state/op types and the result fixup helper for
// the multicycle RV32M divide sequencer.
package div_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned ALUCODE_W = 6;
    localparam int unsigned CNT_W     = $clog2(XLEN);

    // Execute-stage ALU codes for the M-extension divides
    localparam logic [ALUCODE_W-1:0] ALU_DIV  = ALUCODE_W'(24);
    localparam logic [ALUCODE_W-1:0] ALU_DIVU = ALUCODE_W'(25);
    localparam logic [ALUCODE_W-1:0] ALU_REM  = ALUCODE_W'(26);
    localparam logic [ALUCODE_W-1:0] ALU_REMU = ALUCODE_W'(27);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;
    typedef enum logic [1:0] {OP_DIV, OP_DIVU, OP_REM, OP_REMU} div_op_t;

    typedef struct packed {
        logic    valid;
        div_op_t op;
    } div_dec_t;

    function automatic div_dec_t decode_op(input logic [ALUCODE_W-1:0] code);
        div_dec_t d;
        d.valid = 1'b1;
        d.op    = OP_DIV;
        case (code)
            ALU_DIV:  d.op = OP_DIV;
            ALU_DIVU: d.op = OP_DIVU;
            ALU_REM:  d.op = OP_REM;
            ALU_REMU: d.op = OP_REMU;
            default:  d.valid = 1'b0;
        endcase
        return d;
    endfunction

    function automatic logic is_signed_op(input div_op_t op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_rem_op(input div_op_t op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

    // Apply signs and RISC-V special cases to the unsigned quotient/remainder.
    // With a zero divisor the remainder path holds |op1|, so the sign fixup returns op1.
    function automatic logic [XLEN-1:0] finalize(
        input div_dec_t        dec,
        input logic            div0,
        input logic            ovf,
        input logic            neg_quo,
        input logic            neg_rem,
        input logic [XLEN-1:0] quo,
        input logic [XLEN-1:0] rem
    );
        logic [XLEN-1:0] res;
        res = '0;
        if (dec.valid) begin
            if (is_rem_op(dec.op)) begin
                if (ovf)          res = '0;
                else if (neg_rem) res = XLEN'(-rem);
                else              res = rem;
            end else begin
                if (div0)         res = '1;
                else if (ovf)     res = INT_MIN;
                else if (neg_quo) res = XLEN'(-quo);
                else              res = quo;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/div_if.sv
// Request/response handshake bundle between the execute stage and the divide sequencer.
interface div_if;
    import div_pkg::*;

    logic                 req_valid;
    logic                 req_ready;
    logic [ALUCODE_W-1:0] alucode;
    logic [XLEN-1:0]      op1;
    logic [XLEN-1:0]      op2;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [XLEN-1:0]      result;
    logic                 busy;

    modport master (
        output req_valid, alucode, op1, op2, resp_ready,
        input  req_ready, resp_valid, result, busy
    );

    modport slave (
        input  req_valid, alucode, op1, op2, resp_ready,
        output req_ready, resp_valid, result, busy
    );

endinterface

// File: rtl/div_step.sv
// One radix-2 restoring division iteration: shift in the next dividend bit,
// subtract the divisor if it fits and record the quotient bit.
module div_step
    import div_pkg::*;
(
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] trial;
    logic            fits;

    // The difference is below the divisor whenever it is kept, so XLEN bits suffice.
    always_comb begin
        shifted = {rem_i, quo_i[XLEN-1]};
        fits    = (shifted >= {1'b0, divisor_i});
        trial   = shifted[XLEN-1:0] - divisor_i;
        rem_o   = fits ? trial : shifted[XLEN-1:0];
        quo_o   = {quo_i[XLEN-2:0], fits};
    end

endmodule

// File: rtl/div_sequencer.sv
// Multicycle RV32M DIV/DIVU/REM/REMU sequencer, one quotient bit per cycle.
// Define DIV_EARLY_OUT_EN to finish divide-by-zero and signed overflow without CALC.
module div_sequencer
    import div_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    div_if.slave bus
);

`ifdef DIV_EARLY_OUT_EN
    localparam bit EARLY_OUT = 1'b1;
`else
    localparam bit EARLY_OUT = 1'b0;
`endif

    div_state_t       state_q;
    div_state_t       state_d;

    div_dec_t         dec_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic             div0_q;
    logic             ovf_q;
    logic [XLEN-1:0]  rem_q;
    logic [XLEN-1:0]  quo_q;
    logic [XLEN-1:0]  dvsr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  result_q;

    div_dec_t         dec_in;
    logic             signed_in;
    logic             sign1_in;
    logic             sign2_in;
    logic [XLEN-1:0]  abs1_in;
    logic [XLEN-1:0]  abs2_in;
    logic             div0_in;
    logic             ovf_in;
    logic             special_in;
    logic             accept;

    logic [XLEN-1:0]  rem_step;
    logic [XLEN-1:0]  quo_step;

    // Request decode: op kind, signs, magnitudes and special cases
    always_comb begin
        dec_in     = decode_op(bus.alucode);
        signed_in  = dec_in.valid && is_signed_op(dec_in.op);
        sign1_in   = signed_in && bus.op1[XLEN-1];
        sign2_in   = signed_in && bus.op2[XLEN-1];
        abs1_in    = sign1_in ? XLEN'(-bus.op1) : bus.op1;
        abs2_in    = sign2_in ? XLEN'(-bus.op2) : bus.op2;
        div0_in    = dec_in.valid && (bus.op2 == '0);
        ovf_in     = signed_in && (bus.op1 == INT_MIN) && (bus.op2 == '1);
        special_in = div0_in || ovf_in;
        accept     = bus.req_valid && (state_q == IDLE) && !flush;
    end

    div_step u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvsr_q),
        .rem_o     (rem_step),
        .quo_o     (quo_step)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Flush overrides every transition
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        state_d = (EARLY_OUT && special_in) ? DONE : CALC;
                    end
                end
                CALC: begin
                    if (cnt_q == '0) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (bus.resp_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.busy       = 1'b0;
        case (state_q)
            IDLE: bus.req_ready = 1'b1;
            CALC: bus.busy      = 1'b1;
            DONE: begin
                bus.busy       = 1'b1;
                bus.resp_valid = 1'b1;
            end
            default: bus.req_ready = 1'b0;
        endcase
    end

    assign bus.result = result_q;

    // Datapath: operand capture, iteration and result registration; flush leaves result untouched
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dec_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            ovf_q     <= 1'b0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
        end else if (!flush) begin
            if (accept) begin
                dec_q     <= dec_in;
                neg_quo_q <= sign1_in ^ sign2_in;
                neg_rem_q <= sign1_in;
                div0_q    <= div0_in;
                ovf_q     <= ovf_in;
                rem_q     <= '0;
                quo_q     <= abs1_in;
                dvsr_q    <= abs2_in;
                cnt_q     <= CNT_W'(XLEN - 1);
                if (EARLY_OUT && special_in) begin
                    result_q <= finalize(dec_in, div0_in, ovf_in, sign1_in ^ sign2_in,
                                         sign1_in, '1, abs1_in);
                end
            end else if (state_q == CALC) begin
                rem_q <= rem_step;
                quo_q <= quo_step;
                cnt_q <= cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    result_q <= finalize(dec_q, div0_q, ovf_q, neg_quo_q, neg_rem_q,
                                         quo_step, rem_step);
                end
            end
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Randomized self-checking bench for div_sequencer against a latency/arithmetic reference model.
module tb_div_sequencer;
    import div_pkg::*;

`ifdef DIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif
    localparam int NRM_LAT = XLEN + 1;
    localparam int SPL_LAT = EARLY ? 1 : XLEN + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    div_if dif ();

    div_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (dif)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic is_div_code(input logic [ALUCODE_W-1:0] c);
        return (c == ALU_DIV) || (c == ALU_DIVU) || (c == ALU_REM) || (c == ALU_REMU);
    endfunction

    function automatic logic is_special(input logic [ALUCODE_W-1:0] c, input logic [31:0] a,
                                        input logic [31:0] b);
        return (is_div_code(c) && b == 32'd0) ||
               ((c == ALU_DIV || c == ALU_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Architectural RV32M results from plain arithmetic
    function automatic logic [31:0] ref_result(input logic [ALUCODE_W-1:0] c, input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic               ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (c)
            ALU_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            ALU_REMU: return (b == 0) ? a : a % b;
            ALU_DIV:  return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
            ALU_REM:  return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
            default:  return 32'd0;
        endcase
    endfunction

    // Behavioural model: a pending op completes XLEN cycles after acceptance
    bit          m_pend   = 1'b0;
    bit          m_rvalid = 1'b0;
    int          m_left   = 0;
    logic [31:0] m_val    = '0;
    logic [31:0] m_result = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_pend   <= 1'b0;
            m_rvalid <= 1'b0;
            m_result <= '0;
        end else if (flush) begin
            m_pend   <= 1'b0;
            m_rvalid <= 1'b0;
        end else if (m_rvalid) begin
            if (dif.resp_ready) m_rvalid <= 1'b0;
        end else if (m_pend) begin
            if (m_left == 1) begin
                m_pend   <= 1'b0;
                m_rvalid <= 1'b1;
                m_result <= m_val;
            end else begin
                m_left <= m_left - 1;
            end
        end else if (dif.req_valid) begin
            if (EARLY && is_special(dif.alucode, dif.op1, dif.op2)) begin
                m_rvalid <= 1'b1;
                m_result <= ref_result(dif.alucode, dif.op1, dif.op2);
            end else begin
                m_pend <= 1'b1;
                m_left <= XLEN;
                m_val  <= ref_result(dif.alucode, dif.op1, dif.op2);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("resp_valid", 32'(dif.resp_valid), 32'(m_rvalid));
            check("busy", 32'(dif.busy), 32'(m_pend || m_rvalid));
            check("req_ready", 32'(dif.req_ready), 32'(!(m_pend || m_rvalid)));
            check("result", dif.result, m_result);
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (dif.busy !== 1'b0 && n < 200) begin
            dif.resp_ready = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        if (dif.busy !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: busy=%b still set after %0d cycles", dif.busy, n);
        end
    endtask

    task automatic scramble();
        dif.op1     = $urandom;
        dif.op2     = $urandom;
        dif.alucode = ALUCODE_W'($urandom);
    endtask

    task automatic do_op(input string tag, input logic [ALUCODE_W-1:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                         input int hold);
        int lat;
        wait_idle();
        dif.req_valid  = 1'b1;
        dif.alucode    = c;
        dif.op1        = a;
        dif.op2        = b;
        dif.resp_ready = 1'b0;
        @(posedge clk); #1;
        dif.req_valid = 1'b0;
        scramble();
        lat = 1;
        while (dif.resp_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_value"}, dif.result, exp);
        repeat (hold) begin
            @(posedge clk); #1;
            check({tag, "_bp_result"}, dif.result, exp);
            check({tag, "_bp_req_ready"}, 32'(dif.req_ready), 32'd0);
            check({tag, "_bp_busy"}, 32'(dif.busy), 32'd1);
        end
        dif.resp_ready = 1'b1;
        @(posedge clk); #1;
        dif.resp_ready = 1'b0;
        check({tag, "_idle_after"}, 32'(dif.busy), 32'd0);
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [ALUCODE_W-1:0] rnd_code();
        case ($urandom_range(0, 9))
            0, 1:    return ALU_DIV;
            2, 3:    return ALU_DIVU;
            4, 5:    return ALU_REM;
            6, 7:    return ALU_REMU;
            8:       return ALUCODE_W'($urandom);
            default: return ALU_DIV;
        endcase
    endfunction

    typedef struct {
        logic [ALUCODE_W-1:0] code;
        logic [31:0]          a;
        logic [31:0]          b;
        logic [31:0]          exp;
        int                   lat;
    } vec_t;

    initial begin
        vec_t vecs[13];
        int   k;

        dif.req_valid  = 1'b0;
        dif.resp_ready = 1'b0;
        dif.alucode    = '0;
        dif.op1        = '0;
        dif.op2        = '0;

        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        check("reset_req_ready", 32'(dif.req_ready), 32'd1);
        check("reset_result", dif.result, 32'd0);

        vecs[0]  = '{ALU_DIVU, 32'd100,        32'd7,          32'd14,         NRM_LAT};
        vecs[1]  = '{ALU_REMU, 32'd100,        32'd7,          32'd2,          NRM_LAT};
        vecs[2]  = '{ALU_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  NRM_LAT};
        vecs[3]  = '{ALU_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  NRM_LAT};
        vecs[4]  = '{ALU_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  NRM_LAT};
        vecs[5]  = '{ALU_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          NRM_LAT};
        vecs[6]  = '{ALU_DIV,  32'hFFFF_FFF1,  32'd0,          32'hFFFF_FFFF,  SPL_LAT};
        vecs[7]  = '{ALU_REM,  32'h1234_5678,  32'd0,          32'h1234_5678,  SPL_LAT};
        vecs[8]  = '{ALU_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  SPL_LAT};
        vecs[9]  = '{ALU_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          SPL_LAT};
        vecs[10] = '{ALU_REMU, 32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFF,  SPL_LAT};
        vecs[11] = '{6'd0,     32'd100,        32'd7,          32'd0,          NRM_LAT};
        vecs[12] = '{ALU_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  NRM_LAT};

        foreach (vecs[i]) begin
            check($sformatf("vec%0d_model", i), ref_result(vecs[i].code, vecs[i].a, vecs[i].b),
                  vecs[i].exp);
            do_op($sformatf("vec%0d", i), vecs[i].code, vecs[i].a, vecs[i].b, vecs[i].exp,
                  vecs[i].lat, 0);
        end

        // Response backpressure for five cycles
        do_op("backpressure", ALU_DIVU, 32'd100, 32'd7, 32'd14, NRM_LAT, 5);

        // Flush in the tenth cycle after acceptance, then a fresh request
        wait_idle();
        dif.resp_ready = 1'b0;
        dif.req_valid  = 1'b1;
        dif.alucode    = ALU_DIVU;
        dif.op1        = 32'd1000;
        dif.op2        = 32'd3;
        @(posedge clk); #1;
        dif.req_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", 32'(dif.busy), 32'd0);
        check("flush_req_ready", 32'(dif.req_ready), 32'd1);
        check("flush_resp_valid", 32'(dif.resp_valid), 32'd0);
        check("flush_result_kept", dif.result, 32'd14);
        do_op("after_flush", ALU_DIVU, 32'd9, 32'd3, 32'd3, NRM_LAT, 0);

        // Synchronous reset mid-CALC
        dif.req_valid = 1'b1;
        dif.alucode   = ALU_DIVU;
        dif.op1       = 32'd100;
        dif.op2       = 32'd7;
        @(posedge clk); #1;
        dif.req_valid = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst_resp_valid", 32'(dif.resp_valid), 32'd0);
        check("rst_busy", 32'(dif.busy), 32'd0);
        check("rst_req_ready", 32'(dif.req_ready), 32'd1);
        check("rst_result", dif.result, 32'd0);

        // Random traffic with backpressure, stray requests and flushes
        for (int i = 0; i < 150; i++) begin
            wait_idle();
            dif.req_valid  = 1'b1;
            dif.alucode    = rnd_code();
            dif.op1        = rnd_opnd();
            dif.op2        = rnd_opnd();
            dif.resp_ready = 1'($urandom_range(0, 1));
            flush          = ($urandom_range(0, 15) == 0);
            @(posedge clk); #1;
            dif.req_valid = 1'b0;
            flush         = 1'b0;
            k = $urandom_range(0, 45);
            repeat (k) begin
                dif.resp_ready = ($urandom_range(0, 2) != 0);
                dif.req_valid  = ($urandom_range(0, 7) == 0);
                dif.alucode    = rnd_code();
                dif.op1        = rnd_opnd();
                dif.op2        = rnd_opnd();
                flush          = ($urandom_range(0, 63) == 0);
                @(posedge clk); #1;
            end
            dif.req_valid = 1'b0;
            flush         = 1'b0;
            wait_idle();
            dif.resp_ready = 1'b0;
        end

        @(posedge clk); #1;
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
